// File: rtl/audio_sample_streamer.sv
// Decimates the mixed audio word to the codec rate, buffers it, and writes it to both codec channels.
// Latency: a sample captured on tick edge E0 into an empty FIFO strobes out from E1 to E2.
// Backpressure: audio_out_allowed gates pops; a full FIFO drops the tick sample and counts an overrun.
module audio_sample_streamer #(
  parameter int CLK_DIV    = 1042,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      channel_audio_in,
  input  logic             audio_out_allowed,
  output logic             write_audio_out,
  output logic [31:0]      left_channel_audio_out,
  output logic [31:0]      right_channel_audio_out,
  output logic [LVL_W-1:0] fifo_level,
  output logic [15:0]      overrun_count
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int PTR_W = LVL_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [15:0]       ovf_q, ovf_d;
  logic [31:0]       sample_q, sample_d;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic tick;
  logic pop;
  logic push;

  // Sample-rate divider: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    tick  = enable && (cnt_q == CNT_MAX);
    cnt_d = (!enable || tick) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output FSM: pop in IDLE when data and room exist, strobe for one cycle, then one gap cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((level_q != '0) && audio_out_allowed) begin
          pop     = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop on the same edge frees the slot a full-FIFO push needs.
  always_comb begin
    push     = tick && ((level_q != LVL_FULL) || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
    ovf_d    = (tick && !push && (ovf_q != 16'hFFFF)) ? ovf_q + 16'd1 : ovf_q;
    sample_d = pop ? mem_q[rd_ptr_q] : sample_q;
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      sample_q <= sample_d;
    end
  end

  // Sample storage; the popped head is read before a same-edge push can overwrite its slot.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= channel_audio_in;
    end
  end

  assign write_audio_out         = (state_q == S_WRITE);
  assign left_channel_audio_out  = sample_q;
  assign right_channel_audio_out = sample_q;
  assign fifo_level              = level_q;
  assign overrun_count           = ovf_q;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Bench for audio_sample_streamer: directed scenarios plus random traffic against a queue-based model.
// Every step drives inputs, advances one clock, and compares all outputs 1 ns after the edge.
// Backpressure is exercised through audio_out_allowed patterns and enable toggling.
module tb_audio_sample_streamer;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
  localparam int LVL_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [31:0]      din = '0;
  logic             allowed = 1'b0;
  logic             wr;
  logic [31:0]      left_o;
  logic [31:0]      right_o;
  logic [LVL_W-1:0] level_o;
  logic [15:0]      ovf_o;

  audio_sample_streamer #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(DEPTH),
    .LVL_W     (LVL_W)
  ) dut (
    .CLOCK_50               (clk),
    .reset                  (rst_n),
    .enable                 (en),
    .channel_audio_in       (din),
    .audio_out_allowed      (allowed),
    .write_audio_out        (wr),
    .left_channel_audio_out (left_o),
    .right_channel_audio_out(right_o),
    .fifo_level             (level_o),
    .overrun_count          (ovf_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of samples, a count of enabled edges, and a
  // countdown of cycles after a write before the next write may start.
  logic [31:0] m_q[$];
  int          m_en_edges;
  int          m_busy;
  int          m_ovf;
  logic [31:0] m_out;
  bit          m_tick;

  task automatic model_reset();
    m_q.delete();
    m_en_edges = 0;
    m_busy     = 0;
    m_ovf      = 0;
    m_out      = '0;
    m_tick     = 1'b0;
  endtask

  task automatic model_edge();
    bit can_write;
    can_write = (m_busy == 0) && (m_q.size() != 0) && allowed;
    if (m_busy > 0) m_busy--;
    if (can_write) begin
      m_out  = m_q.pop_front();
      m_busy = 2;
    end
    m_en_edges = en ? m_en_edges + 1 : 0;
    m_tick     = en && ((m_en_edges % CLK_DIV) == 0);
    if (m_tick) begin
      if (m_q.size() < DEPTH) m_q.push_back(din);
      else if (m_ovf < 65535) m_ovf++;
    end
  endtask

  task automatic compare_all();
    check("strobe", {31'b0, wr}, {31'b0, (m_busy == 2)});
    check("left", left_o, m_out);
    check("right", right_o, m_out);
    check("level", {28'b0, level_o}, m_q.size());
    check("overrun", {16'b0, ovf_o}, m_ovf);
  endtask

  task automatic step(input bit e, input logic [31:0] d, input bit a);
    en      = e;
    din     = d;
    allowed = a;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  int          n_strb;
  int          last_t;
  logic [31:0] v;
  int          mode;
  bit          ra;
  bit          re;

  initial begin
    model_reset();

    // Reset held, then released with no stimulus.
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    n_strb = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'hDEAD_BEEF, 1'b1);
      if (wr) n_strb++;
    end
    check("idle_nostrobe", n_strb, 0);

    // Steady stream: one write per tick, FIFO never above one entry.
    n_strb = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h0000_1234, 1'b1);
      if (wr) n_strb++;
      if (level_o > 1) check("s2_level_le1", {28'b0, level_o}, 1);
    end
    check("s2_nstrobes", n_strb, 4);
    check("s2_left", left_o, 32'h0000_1234);

    // Drain, then fill with allowed low: 10 ticks, 8 kept, 2 dropped.
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    v = 32'd1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, v, 1'b0);
      if (m_tick) v = v + 32'd1;
    end
    check("s3_level", {28'b0, level_o}, 8);
    check("s3_ovf", {16'b0, ovf_o}, 2);
    n_strb = 0;
    last_t = -3;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0, 1'b1);
      if (wr) begin
        check("s3_data", left_o, n_strb + 1);
        check("s3_spacing", i - last_t, 3);
        last_t = i;
        n_strb++;
      end
    end
    check("s3_nstrobes", n_strb, 8);
    check("s3_drained", {28'b0, level_o}, 0);

    // Full FIFO: a tick on the same edge as the IDLE pop is still accepted.
    for (int i = 0; i < 32; i++) step(1'b1, 32'h100 + i, 1'b0);
    check("s4_full", {28'b0, level_o}, 8);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200, 1'b0);
    step(1'b1, 32'hCAFE_0001, 1'b1);
    check("s4_strobe", {31'b0, wr}, 1);
    check("s4_level", {28'b0, level_o}, 8);
    check("s4_ovf", {16'b0, ovf_o}, 2);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1);

    // Disabled capture keeps draining; re-enable pushes on the 4th edge.
    for (int i = 0; i < 12; i++) step(1'b1, 32'h300 + i, 1'b0);
    check("s5_buffered", {28'b0, level_o}, 3);
    n_strb = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h999, 1'b1);
      if (wr) n_strb++;
    end
    check("s5_nstrobes", n_strb, 3);
    check("s5_empty", {28'b0, level_o}, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h777, 1'b0);
    check("s5_nopush_yet", {28'b0, level_o}, 0);
    step(1'b1, 32'h777, 1'b0);
    check("s5_push_4th", {28'b0, level_o}, 1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Random traffic in 16-cycle blocks with varied backpressure.
    for (int b = 0; b < 150; b++) begin
      mode = $urandom_range(0, 3);
      re   = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 16; i++) begin
        case (mode)
          0:       ra = 1'b1;
          1:       ra = 1'b0;
          2:       ra = ($urandom_range(0, 1) == 1);
          default: ra = ($urandom_range(0, 7) == 0);
        endcase
        step(re, $urandom, ra);
      end
    end

    // Asynchronous reset while a write strobe is active with 5 entries left.
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, 32'h500 + i, 1'b0);
    step(1'b0, '0, 1'b1);
    check("s6_strobe", {31'b0, wr}, 1);
    check("s6_level5", {28'b0, level_o}, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_strobe", {31'b0, wr}, 0);
    check("s6_rst_level", {28'b0, level_o}, 0);
    check("s6_rst_ovf", {16'b0, ovf_o}, 0);
    check("s6_rst_left", left_o, 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    n_strb = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h0000_1234, 1'b1);
      if (wr) n_strb++;
    end
    check("s6_nstrobes", n_strb, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_sample_streamer.md
Name: audio_sample_streamer

Overview:
- Downstream stage of the channel mixer.
- Decimates the 50 MHz mixed channel_audio_out word to the codec sample rate and buffers samples in a small FIFO.
- Drives the audio-core write handshake, duplicating each sample onto the left and right channels.
- Sits between the synthesizer mixer output and the board audio core's output FIFO interface.

Parameters:
CLK_DIV, 1042, clock cycles per output sample (50 MHz / 1042 ≈ 48 kHz); legal range ≥ 4
FIFO_DEPTH, 8, sample buffer entries; power of two, ≥ 2
LVL_W, 4, width of fifo_level; equals log2(FIFO_DEPTH)+1

Ports:
CLOCK_50  input  1  system clock; all state on its rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
enable  input  1  1 = sample capture running; 0 = capture halted
channel_audio_in  input  32  mixed audio word from the synthesizer mixer
audio_out_allowed  input  1  audio core has space in both its left and right FIFOs
write_audio_out  output  1  one-cycle write strobe to the audio core
left_channel_audio_out  output  32  sample presented with the write strobe
right_channel_audio_out  output  32  identical to left_channel_audio_out
fifo_level  output  LVL_W  current FIFO occupancy, 0..FIFO_DEPTH
overrun_count  output  16  samples dropped because the FIFO was full; saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, asynchronous):
  - Divider counter = 0; FIFO empty; FSM = IDLE.
  - All outputs 0: write_audio_out=0, both channel outputs 32'h0, fifo_level=0, overrun_count=0.
  - Takes effect mid-operation with no wait for a clock edge.
- Divider:
  - Counter runs 0..CLK_DIV-1 while enable=1.
  - tick = (counter == CLK_DIV-1); the counter wraps to 0 on the same edge.
  - enable=0 forces the counter to 0 and suppresses tick.
  - After enable rises, the first tick occurs on the CLK_DIV-th rising edge.
- Capture:
  - On a tick edge, channel_audio_in is pushed into the FIFO unmodified, all 32 bits, no sign conversion.
  - Push succeeds if fifo_level < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the sample is discarded and overrun_count increments, saturating.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH; order preserved.
  - fifo_level is registered and updates on the push/pop edge.
  - Simultaneous push and pop leaves the level unchanged.
  - Pop from empty never occurs.
- Output FSM (three states):
  - IDLE: if fifo_level ≠ 0 and audio_out_allowed=1, pop the head on this edge, load it into both channel outputs, set write_audio_out=1, go to WRITE. Otherwise stay in IDLE with write_audio_out=0.
  - WRITE: write_audio_out=1 for exactly this one cycle. Next edge: write_audio_out=0, go to GAP.
  - GAP: one idle cycle so audio_out_allowed can update, then go to IDLE.
  - audio_out_allowed is sampled only in IDLE; deasserting it during WRITE does not cancel the strobe.
- Channel outputs hold the last written sample between strobes.
- Latency: a sample captured on tick edge E0 into an empty FIFO, with allowed=1, has write_audio_out high from E1 to E2.
- Throughput: at most one write every 3 cycles, far above the tick rate, so the FIFO only fills while audio_out_allowed=0.
- enable=0 does not flush the FIFO; buffered samples continue to drain.

Test Plan:
1. Hold reset=0, then release; no stimulus → all outputs 0, fifo_level 0, write_audio_out never asserted.
2. CLK_DIV=4, enable=1, channel_audio_in=32'h0000_1234, allowed=1 → write_audio_out pulses once every 4 cycles, high 1 cycle after each tick edge; both channels = 32'h0000_1234; fifo_level ≤ 1.
3. CLK_DIV=4, allowed=0, inputs 1..10 on successive ticks → fifo_level=8, overrun_count=2. Then allowed=1 → 8 strobes spaced exactly 3 cycles apart, data 1..8 in order; fifo_level returns to 0.
4. FIFO full with allowed=1 and a tick coinciding with the IDLE pop edge → push accepted; fifo_level stays 8; overrun_count unchanged.
5. enable=0 for 20 cycles with 3 samples buffered, allowed=1 → 3 strobes, no new pushes, counter held at 0. Re-enable → first new push on the 4th edge.
6. Assert reset=0 asynchronously while write_audio_out=1 and fifo_level=5 → write_audio_out, fifo_level and overrun_count go to 0 before the next clock edge. After release, behaviour is as in scenario 2.
